crossing_request: RTL and testbench
===================================

Name: crossing_request

Overview:
- Pedestrian/cyclist push-button front end that sits directly upstream of the crossing light-sequence controller and drives its `start` input.
- Synchronises and debounces the raw button, then latches one request per press.
- Lights a WAIT lamp while a request is outstanding.
- Issues a single-cycle `start` pulse.
- Enforces a minimum lockout interval between successive crossings, so repeated presses cannot retrigger the sequence early.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the button synchroniser chain (≥2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced level changes (≥1).
- LOCKOUT_CYCLES, 16, cycles after a `start` pulse during which no new `start` may be issued (≥1).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- button_in  input  1  raw, asynchronous, bouncy push-button; high = pressed.
- start  output  1  one-cycle request pulse to the light-sequence controller.
- wait_lamp  output  1  high while a request is latched but not yet served.
- req_count  output  8  accepted-request counter (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock (`clock`); reset is synchronous and active-high (`reset`).
  - Reset clears synchroniser, debounce counter, debounced level (0), pending flag, lockout counter and FSM state (IDLE).
  - Reset values: start=0, wait_lamp=0, req_count=0.
- Synchroniser: SYNC_STAGES-deep shift chain; its last stage is `sync`.
- Debounce:
  - A counter counts consecutive cycles in which `sync` differs from `db_level`.
  - The counter clears whenever `sync` equals `db_level`.
  - When the count reaches DEBOUNCE_CYCLES, `db_level` toggles and the counter clears.
  - A press event is the cycle in which `db_level` goes 0→1. Releases generate no event.
- Pending flag:
  - Set on a press event.
  - Cleared in the cycle `start` is asserted.
  - A press event in the same cycle as `start` keeps the flag set; the new press is not lost.
- wait_lamp = pending flag, registered with no extra delay.
- FSM states: IDLE, FIRE, LOCKOUT.
  - IDLE: if pending → FIRE, else stay.
  - FIRE: start=1 for exactly this cycle; load lockout counter with LOCKOUT_CYCLES-1; → LOCKOUT.
  - LOCKOUT: decrement each cycle. At 0: if pending → FIRE, else → IDLE. Presses here set pending only.
- start is a Moore output, high only in FIRE, so two `start` pulses are at least LOCKOUT_CYCLES+1 cycles apart.
- Latency:
  - button_in held high from cycle 0 → db_level high at cycle SYNC_STAGES+DEBOUNCE_CYCLES.
  - pending high the next cycle.
  - start high the cycle after that.
  - With defaults: start at cycle 8.
- Multiple presses during one wait or lockout collapse into one request.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.
- Counter widths are sized with $clog2 of the parameter, minimum 1 bit.

Optional Feature:
- Macro: CROSSING_REQ_COUNT_EN.
- Defined: req_count increments on every `start` pulse and saturates at 255 (no wrap). It resets to 0.
- Undefined: no counter logic; req_count is tied to 8'd0. The port remains, so the interface is unchanged.

Decomposition:
- Package crossing_pkg holds:
  - the FSM state typedef/localparams (IDLE=2'd0, FIRE=2'd1, LOCKOUT=2'd2);
  - REQ_COUNT_W=8 and REQ_COUNT_MAX=8'hFF.
- One sub-module, button_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES), containing synchroniser plus debounce. Outputs are db_level and a press_evt pulse.
- crossing_request contains the FSM, pending flag, lockout counter and optional counter.

Test Plan:
1. Reset held for 3 cycles, then button_in=1 from cycle 0 → wait_lamp=1 at cycle 7, start=1 only at cycle 8, wait_lamp=0 at cycle 9.
2. button_in toggling every 2 cycles for 20 cycles, then held 0 → start and wait_lamp never assert.
3. Press served at cycle 8; second clean press during lockout at cycle 12 → wait_lamp stays 1 until the next start, which is exactly at cycle 25 (8+16+1).
4. Five separate presses all within one lockout → exactly one further start pulse after lockout expires.
5. Reset asserted in LOCKOUT with pending=1 → next cycle start=0, wait_lamp=0, state IDLE; no start pulse without a new press.
6. With CROSSING_REQ_COUNT_EN: 3 served requests → req_count=3. Force 260 requests → req_count=255. Without the macro, req_count=0 throughout.

Source files
------------

// File: rtl/crossing_pkg.sv
// Shared types and constants for the crossing push-button front end.
// Optional request counter is enabled by defining CROSSING_REQ_COUNT_EN.
package crossing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int REQ_COUNT_W = 8;
  localparam logic [REQ_COUNT_W-1:0] REQ_COUNT_MAX = 8'hFF;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises the raw button and debounces it; press_evt pulses for one
// cycle in the cycle the debounced level rises.
module button_debounce
  import crossing_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic db_level,
  output logic press_evt
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CW-1:0]          cnt;

  assign sync = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain <= '0;
      cnt        <= '0;
      db_level   <= 1'b0;
      press_evt  <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], button_in};
      press_evt  <= 1'b0;
      // The count has seen DEBOUNCE_CYCLES consecutive disagreeing cycles.
      if (cnt == CNT_TOP) begin
        db_level  <= ~db_level;
        cnt       <= '0;
        press_evt <= ~db_level;
      end else if (sync != db_level) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/crossing_request.sv
// Crossing request front end: latches debounced presses, fires start and
// enforces a lockout between crossings. CROSSING_REQ_COUNT_EN adds req_count.
module crossing_request
  import crossing_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_in,
  output logic                   start,
  output logic                   wait_lamp,
  output logic [REQ_COUNT_W-1:0] req_count
);

  localparam int LW = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_TOP = LW'(LOCKOUT_CYCLES - 1);

  logic          db_level;
  logic          press_evt;
  logic          press;
  logic          pending;
  logic [LW-1:0] lock_cnt;
  state_t        state;

  button_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .button_in(button_in),
    .db_level (db_level),
    .press_evt(press_evt)
  );

  // press_evt is only ever raised alongside a high debounced level.
  assign press     = press_evt & db_level;
  assign wait_lamp = pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      pending  <= 1'b0;
      lock_cnt <= '0;
    end else begin
      pending <= press | (pending & ~start);
      start   <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state <= FIRE;
            start <= 1'b1;
          end
        end
        FIRE: begin
          lock_cnt <= LOCK_TOP;
          state    <= LOCKOUT;
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            if (pending) begin
              state <= FIRE;
              start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CROSSING_REQ_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      req_count <= '0;
    end else if (start && (req_count != REQ_COUNT_MAX)) begin
      req_count <= req_count + REQ_COUNT_W'(1);
    end
  end
`else
  assign req_count = '0;
`endif

endmodule

// File: tb/tb_crossing_request.sv
// Directed bench for crossing_request: per-cycle vector tables plus
// hand-written lockout, reset-in-lockout and request-counter sequences.
module tb_crossing_request;
  import crossing_pkg::*;

  typedef struct {
    logic button;
    logic start;
    logic wait_l;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button_in = 1'b0;
  logic       button_long = 1'b0;
  logic       start, wait_lamp, start_long, wait_long;
  logic [7:0] req_count, req_count_long;

  int n_vec = 0;
  int n_bad = 0;

  crossing_request dut (
    .clock    (clock),
    .reset    (reset),
    .button_in(button_in),
    .start    (start),
    .wait_lamp(wait_lamp),
    .req_count(req_count)
  );

  crossing_request #(.LOCKOUT_CYCLES(80)) dut_long (
    .clock    (clock),
    .reset    (reset),
    .button_in(button_long),
    .start    (start_long),
    .wait_lamp(wait_long),
    .req_count(req_count_long)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int cyc, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    button_in   = 1'b0;
    button_long = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  vec_t va[31];
  vec_t vb[30];
  int   n_starts;
  int   t2;
  int   exp_cnt;

  initial begin
    // Trace A: press at 0, release at 9, re-press at 16 (lands in lockout).
    for (int k = 0; k < 31; k++) begin
      va[k].button = (k <= 8) || (k >= 16);
      va[k].start  = (k == 8) || (k == 25);
      va[k].wait_l = (k == 7) || (k == 8) || (k >= 23 && k <= 25);
    end
    // Trace B: bounce every 2 cycles, then quiet.
    for (int k = 0; k < 30; k++) begin
      vb[k].button = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
      vb[k].start  = 1'b0;
      vb[k].wait_l = 1'b0;
    end

    do_reset();
    check("reset_start", 0, int'(start), 0);
    check("reset_wait", 0, int'(wait_lamp), 0);
    check("reset_count", 0, int'(req_count), 0);

    for (int k = 0; k < 31; k++) begin
      button_in = va[k].button;
      @(posedge clock); #1;
      check("a_start", k, int'(start), int'(va[k].start));
      check("a_wait", k, int'(wait_lamp), int'(va[k].wait_l));
    end

    do_reset();
    for (int k = 0; k < 30; k++) begin
      button_in = vb[k].button;
      @(posedge clock); #1;
      check("b_start", k, int'(start), int'(vb[k].start));
      check("b_wait", k, int'(wait_lamp), int'(vb[k].wait_l));
    end

    // Reset while in LOCKOUT with a request pending.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      button_in = va[k].button;
      @(posedge clock);
    end
    #1;
    check("pre_reset_wait", 23, int'(wait_lamp), 1);
    reset     = 1'b1;
    button_in = 1'b0;
    @(posedge clock); #1;
    check("rst_lock_start", 24, int'(start), 0);
    check("rst_lock_wait", 24, int'(wait_lamp), 0);
    check("rst_lock_state", 24, int'(dut.state), int'(IDLE));
    reset    = 1'b0;
    n_starts = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (start) n_starts++;
    end
    check("rst_lock_nostart", 64, n_starts, 0);

    // Five presses inside one long lockout collapse into one request.
    do_reset();
    n_starts = 0;
    t2       = -1;
    for (int k = 0; k < 150; k++) begin
      if (k <= 8)                 button_long = 1'b1;
      else if (k < 16 || k >= 86) button_long = 1'b0;
      else                        button_long = (((k - 16) % 14) < 7);
      @(posedge clock); #1;
      if (start_long) begin
        n_starts++;
        if (n_starts == 2) t2 = k;
      end
    end
    check("collapse_count", 150, n_starts, 2);
    check("collapse_time", 150, t2, 89);

    // Request counter: 3 served requests, then saturation past 255.
    do_reset();
    for (int p = 0; p < 260; p++) begin
      for (int c = 0; c < 24; c++) begin
        button_in = (c < 12);
        @(posedge clock); #1;
      end
      if (p == 2) begin
`ifdef CROSSING_REQ_COUNT_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        check("count_3", p, int'(req_count), exp_cnt);
      end
    end
`ifdef CROSSING_REQ_COUNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    check("count_sat", 260, int'(req_count), exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
